inst_fifo: RTL and testbench

INST_FIFO -- requirements
Module: inst_fifo

---
 rtl/inst_fifo.sv | 122 ++++++++++++
 tb/tb_inst_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Instruction buffer between fetch and decode: two-wide in, two-wide out.
// Ports: clk, rst (sync, active-high), flush; push_valid[1:0], push_pc0/1,
// push_inst0/1, push_ready; head_valid_a/b, head_pc_a/b, head_inst_a/b;
// pop_cnt[1:0] (3 treated as 2); occupancy[CW-1:0].
module inst_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_valid,
  input  logic [31:0]   push_pc0,
  input  logic [31:0]   push_pc1,
  input  logic [31:0]   push_inst0,
  input  logic [31:0]   push_inst1,
  output logic          push_ready,
  output logic          head_valid_a,
  output logic          head_valid_b,
  output logic [31:0]   head_pc_a,
  output logic [31:0]   head_inst_a,
  output logic [31:0]   head_pc_b,
  output logic [31:0]   head_inst_b,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LIM = CW'(DEPTH - 2);

  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_wp;
  logic [CW-1:0] r_cnt;

  logic [AW-1:0] w_rp1;
  logic [AW-1:0] w_wp1;
  logic          w_ready;
  logic          w_acc;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_req;
  logic [1:0]    w_pop;
  logic          w_va;
  logic          w_vb;

  assign w_rp1 = r_rp + 1'b1;
  assign w_wp1 = r_wp + 1'b1;

  // Needs room for a full pair; a same-cycle pop is not credited.
  assign w_ready = (r_cnt <= LIM);
  assign w_acc   = w_ready & ~flush;

  always_comb begin
    w_push_n = 2'd0;
    if (w_acc) begin
      unique case (push_valid)
        2'b11:   w_push_n = 2'd2;
        2'b01,
        2'b10:   w_push_n = 2'd1;
        default: w_push_n = 2'd0;
      endcase
    end
  end

  // Clamp request to 2, then to what is actually held.
  assign w_pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;

  always_comb begin
    w_pop = w_pop_req;
    if (r_cnt == '0)
      w_pop = 2'd0;
    else if (r_cnt == CW'(1) && w_pop_req != 2'd0)
      w_pop = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      r_rp  <= r_rp + AW'(w_pop);
      r_wp  <= r_wp + AW'(w_push_n);
      r_cnt <= r_cnt + CW'(w_push_n) - CW'(w_pop);
    end
  end

  // Storage carries no reset; validity comes from r_cnt alone.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (push_valid[0]) begin
        r_pc[r_wp]   <= push_pc0;
        r_inst[r_wp] <= push_inst0;
        if (push_valid[1]) begin
          r_pc[w_wp1]   <= push_pc1;
          r_inst[w_wp1] <= push_inst1;
        end
      end else if (push_valid[1]) begin
        r_pc[r_wp]   <= push_pc1;
        r_inst[r_wp] <= push_inst1;
      end
    end
  end

  assign w_va = (r_cnt >= CW'(1));
  assign w_vb = (r_cnt >= CW'(2));

  assign push_ready   = w_ready;
  assign head_valid_a = w_va;
  assign head_valid_b = w_vb;
  assign head_pc_a    = w_va ? r_pc[r_rp]    : '0;
  assign head_inst_a  = w_va ? r_inst[r_rp]  : '0;
  assign head_pc_b    = w_vb ? r_pc[w_rp1]   : '0;
  assign head_inst_b  = w_vb ? r_inst[w_rp1] : '0;
  assign occupancy    = r_cnt;

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo (DEPTH = 8).
// Hand-computed expectations, one checking task.
module tb_inst_fifo;

  localparam logic [31:0] IOFS = 32'h0BAD_0000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  push_valid;
  logic [31:0] push_pc0;
  logic [31:0] push_pc1;
  logic [31:0] push_inst0;
  logic [31:0] push_inst1;
  logic        push_ready;
  logic        head_valid_a;
  logic        head_valid_b;
  logic [31:0] head_pc_a;
  logic [31:0] head_inst_a;
  logic [31:0] head_pc_b;
  logic [31:0] head_inst_b;
  logic [1:0]  pop_cnt;
  logic [3:0]  occupancy;

  int checks;
  int errors;

  inst_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_pc0     (push_pc0),
    .push_pc1     (push_pc1),
    .push_inst0   (push_inst0),
    .push_inst1   (push_inst1),
    .push_ready   (push_ready),
    .head_valid_a (head_valid_a),
    .head_valid_b (head_valid_b),
    .head_pc_a    (head_pc_a),
    .head_inst_a  (head_inst_a),
    .head_pc_b    (head_pc_b),
    .head_inst_b  (head_inst_b),
    .pop_cnt      (pop_cnt),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit past the edge.
  task automatic step(input logic [1:0]  pv,
                      input logic [31:0] pc0,
                      input logic [31:0] pc1,
                      input logic [1:0]  pop,
                      input logic        fl,
                      input logic        rs);
    push_valid = pv;
    push_pc0   = pc0;
    push_pc1   = pc1;
    push_inst0 = pc0 + IOFS;
    push_inst1 = pc1 + IOFS;
    pop_cnt    = pop;
    flush      = fl;
    rst        = rs;
    @(posedge clk);
    #1;
    push_valid = 2'b00;
    pop_cnt    = 2'd0;
    flush      = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; flush = 1'b0; push_valid = 2'b00; pop_cnt = 2'd0;
    push_pc0 = '0; push_pc1 = '0; push_inst0 = '0; push_inst1 = '0;

    step(2'b11, 32'hAAAA, 32'hBBBB, 2'd0, 1'b0, 1'b1);
    step(2'b00, 0, 0, 2'd0, 1'b0, 1'b1);
    chk("rst_va",   {31'b0, head_valid_a}, 0);
    chk("rst_vb",   {31'b0, head_valid_b}, 0);
    chk("rst_pca",  head_pc_a, 0);
    chk("rst_insta", head_inst_a, 0);
    chk("rst_pcb",  head_pc_b, 0);
    chk("rst_occ",  {28'b0, occupancy}, 0);
    chk("rst_rdy",  {31'b0, push_ready}, 1);

    // Pair push, visible next cycle.
    step(2'b11, 32'h1000, 32'h1004, 2'd0, 1'b0, 1'b0);
    chk("p1_va",   {31'b0, head_valid_a}, 1);
    chk("p1_vb",   {31'b0, head_valid_b}, 1);
    chk("p1_pca",  head_pc_a, 32'h1000);
    chk("p1_pcb",  head_pc_b, 32'h1004);
    chk("p1_insta", head_inst_a, 32'h1000 + IOFS);
    chk("p1_instb", head_inst_b, 32'h1004 + IOFS);
    chk("p1_occ",  {28'b0, occupancy}, 2);

    // Push and pop together.
    step(2'b11, 32'h1008, 32'h100C, 2'd1, 1'b0, 1'b0);
    chk("pp_occ", {28'b0, occupancy}, 3);
    chk("pp_pca", head_pc_a, 32'h1004);
    chk("pp_pcb", head_pc_b, 32'h1008);

    // Fill to 7 using all slot patterns.
    step(2'b11, 32'h1010, 32'h1014, 2'd0, 1'b0, 1'b0);
    chk("f5_occ", {28'b0, occupancy}, 5);
    step(2'b01, 32'h1018, 32'hDEAD, 2'd0, 1'b0, 1'b0);
    chk("f6_occ", {28'b0, occupancy}, 6);
    chk("f6_rdy", {31'b0, push_ready}, 1);
    step(2'b10, 32'hDEAD, 32'h101C, 2'd0, 1'b0, 1'b0);
    chk("f7_occ", {28'b0, occupancy}, 7);
    chk("f7_rdy", {31'b0, push_ready}, 0);
    step(2'b11, 32'hBAD0, 32'hBAD4, 2'd0, 1'b0, 1'b0);
    chk("drop_occ", {28'b0, occupancy}, 7);
    chk("drop_pca", head_pc_a, 32'h1004);
    step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
    chk("pop2_occ", {28'b0, occupancy}, 5);
    chk("pop2_rdy", {31'b0, push_ready}, 1);
    chk("pop2_pca", head_pc_a, 32'h100C);
    chk("pop2_pcb", head_pc_b, 32'h1010);
    step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
    chk("d3_pca", head_pc_a, 32'h1014);
    chk("d3_pcb", head_pc_b, 32'h1018);
    step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
    chk("d1_occ", {28'b0, occupancy}, 1);
    chk("d1_pca", head_pc_a, 32'h101C);
    chk("d1_vb",  {31'b0, head_valid_b}, 0);
    chk("d1_pcb", head_pc_b, 0);

    // Over-pop a single entry.
    step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
    chk("e_occ", {28'b0, occupancy}, 0);
    chk("e_va",  {31'b0, head_valid_a}, 0);
    step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
    chk("e2_occ", {28'b0, occupancy}, 0);
    step(2'b10, 32'hDEAD, 32'h2004, 2'd0, 1'b0, 1'b0);
    chk("s1_pca", head_pc_a, 32'h2004);
    chk("s1_vb",  {31'b0, head_valid_b}, 0);
    chk("s1_occ", {28'b0, occupancy}, 1);

    // Wrap-around streaming at constant occupancy.
    step(2'b00, 0, 0, 2'd1, 1'b0, 1'b0);
    step(2'b11, 32'h3000, 32'h3004, 2'd0, 1'b0, 1'b0);
    chk("w0_pca", head_pc_a, 32'h3000);
    for (int k = 1; k <= 20; k++) begin
      step(2'b11, 32'h3000 + 32'(8 * k), 32'h3004 + 32'(8 * k),
           2'd2, 1'b0, 1'b0);
      chk("wr_pca", head_pc_a, 32'h3000 + 32'(8 * k));
      chk("wr_pcb", head_pc_b, 32'h3004 + 32'(8 * k));
      chk("wr_occ", {28'b0, occupancy}, 2);
    end

    // Flush with concurrent push and pop.
    step(2'b11, 32'h30B0, 32'h30B4, 2'd0, 1'b0, 1'b0);
    step(2'b01, 32'h30B8, 32'hDEAD, 2'd0, 1'b0, 1'b0);
    chk("pf_occ", {28'b0, occupancy}, 5);
    step(2'b11, 32'hF000, 32'hF004, 2'd2, 1'b1, 1'b0);
    chk("fl_occ", {28'b0, occupancy}, 0);
    chk("fl_va",  {31'b0, head_valid_a}, 0);
    chk("fl_rdy", {31'b0, push_ready}, 1);
    step(2'b11, 32'h4000, 32'h4004, 2'd0, 1'b0, 1'b0);
    chk("af_pca", head_pc_a, 32'h4000);
    chk("af_pcb", head_pc_b, 32'h4004);
    chk("af_occ", {28'b0, occupancy}, 2);

    // Reset mid-operation beats a push.
    step(2'b11, 32'hE000, 32'hE004, 2'd0, 1'b0, 1'b1);
    chk("mr_occ", {28'b0, occupancy}, 0);
    chk("mr_va",  {31'b0, head_valid_a}, 0);
    step(2'b01, 32'h5000, 32'hDEAD, 2'd0, 1'b0, 1'b0);
    chk("ar_pca", head_pc_a, 32'h5000);
    chk("ar_occ", {28'b0, occupancy}, 1);

    // pop_cnt 3 behaves as 2.
    step(2'b11, 32'h5004, 32'h5008, 2'd0, 1'b0, 1'b0);
    chk("p3a_occ", {28'b0, occupancy}, 3);
    step(2'b00, 0, 0, 2'd3, 1'b0, 1'b0);
    chk("p3_occ", {28'b0, occupancy}, 1);
    chk("p3_pca", head_pc_a, 32'h5008);
    chk("p3_inst", head_inst_a, 32'h5008 + IOFS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
